// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: default WIDTH/DIGITS, the BLANK nibble shown on overflow,
// the converter state encoding and the per-digit add-3 helper.
package bin_to_bcd_pkg;

    localparam int DEF_WIDTH  = 14;
    localparam int DEF_DIGITS = 4;

    // Nibble value the 7-segment stage renders as all segments off.
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Double-dabble correction: a digit of 5 or more would exceed 9 after
    // the next doubling, so pre-add 3 to make it carry into the next nibble.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// Request/result bundle between a requester and the binary-to-BCD converter.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while busy is low.
//
// Signals: number/start (request), busy/done/bcd/ovf (status and result).
// Modports: master = requester side, slave = converter side.
interface bin_to_bcd_if
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
);
    logic [WIDTH-1:0]    number;
    logic                start;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;

    modport master (
        output number,
        output start,
        input  busy,
        input  done,
        input  bcd,
        input  ovf
    );

    modport slave (
        input  number,
        input  start,
        output busy,
        output done,
        output bcd,
        output ovf
    );
endinterface

// File: rtl/bin_to_bcd_digit_adjust.sv
// Single BCD digit correction step for the shift-add-3 converter.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: din (scratch digit before shift), dout (digit, +3 if din >= 5).
module bcd_digit_adjust
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = add3_if_ge5(din);
endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Latency: done pulses WIDTH edges after start is sampled; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; no request queuing.
//
// Ports: clk, reset (async, active high), io (slave modport):
//   number/start in; busy, done (1-cycle pulse), bcd (digit 0 in [3:0]), ovf out.
// Values above 10^DIGITS-1 show every nibble as BLANK with ovf set.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
)(
    input  logic         clk,
    input  logic         reset,
    bin_to_bcd_if.slave  io
);
    // One spare digit above the displayed ones catches overflow.
    localparam int SW = 4*DIGITS + 4;
    localparam int CW = $clog2(WIDTH + 1);

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    bin_q, bin_nxt;
    logic [SW-1:0]       scr_q, scr_nxt, scr_adj;
    logic [CW-1:0]       cnt_q, cnt_nxt;
    logic [4*DIGITS-1:0] bcd_q, bcd_nxt;
    logic                ovf_q, ovf_nxt;
    logic                done_q, done_nxt;

    // Correct every scratch digit, including the overflow digit.
    for (genvar i = 0; i < DIGITS + 1; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (scr_q[4*i +: 4]),
            .dout (scr_adj[4*i +: 4])
        );
    end

    always_comb begin
        state_nxt = state;
        bin_nxt   = bin_q;
        scr_nxt   = scr_q;
        cnt_nxt   = cnt_q;
        bcd_nxt   = bcd_q;
        ovf_nxt   = ovf_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (io.start) begin
                    bin_nxt   = io.number;
                    scr_nxt   = '0;
                    cnt_nxt   = CW'(WIDTH);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                {scr_nxt, bin_nxt} = {scr_adj, bin_q} << 1;
                cnt_nxt = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    // All lower digits are valid 0..9 after the last shift,
                    // so the value exceeds 10^DIGITS-1 exactly when the
                    // spare top digit is non-zero.
                    if (scr_nxt[SW-1 -: 4] != 4'd0) begin
                        ovf_nxt = 1'b1;
                        bcd_nxt = {DIGITS{BLANK}};
                    end else begin
                        ovf_nxt = 1'b0;
                        bcd_nxt = scr_nxt[4*DIGITS-1:0];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            bin_q  <= '0;
            scr_q  <= '0;
            cnt_q  <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            bin_q  <= bin_nxt;
            scr_q  <= scr_nxt;
            cnt_q  <= cnt_nxt;
            bcd_q  <= bcd_nxt;
            ovf_q  <= ovf_nxt;
            done_q <= done_nxt;
        end
    end

    assign io.busy = (state == SHIFT);
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
    assign io.ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: table vectors, random values and
// hand-written sequences for ignored/accepted starts, mid-run reset and
// input changes during a conversion. Results are scoreboarded on done.
module tb_bin_to_bcd;
    import bin_to_bcd_pkg::*;

    localparam int W = 14;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin_to_bcd_if #(.WIDTH(W), .DIGITS(D)) intf();

    bin_to_bcd #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (intf.slave)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [13:0] num;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference via integer division.
    function automatic exp_t model(input int n);
        exp_t r;
        if (n > 9999) begin
            r.bcd = 16'hFFFF;
            r.ovf = 1'b1;
        end else begin
            r.bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest request.
    always @(negedge clk) begin
        exp_t e;
        if (intf.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with bcd=%0h, required no done", intf.bcd);
            end else begin
                e = sb.pop_front();
                check("bcd", 32'(intf.bcd), 32'(e.bcd));
                check("ovf", 32'(intf.ovf), 32'(e.ovf));
            end
        end
    end

    // Called at a negedge with the converter idle. Drives one request,
    // optionally changes number at negedge k=chg_at, and checks timing.
    task automatic run_one(input logic [13:0] n, input int chg_at,
                           input logic [13:0] chg_val, input exp_t e);
        int k;
        int busy_cnt;
        intf.number = n;
        intf.start  = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        intf.start = 1'b0;
        k = 0;
        busy_cnt = 0;
        while (intf.done !== 1'b1 && k < 40) begin
            if (intf.busy === 1'b1) busy_cnt++;
            if (k == chg_at) intf.number = chg_val;
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'd14);
        check("busy_cycles", 32'(busy_cnt), 32'd14);
        check("busy_at_done", 32'(intf.busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(intf.done), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int   k;
        int   n;
        exp_t last;

        vecs[0] = '{14'd0,     16'h0000, 1'b0};
        vecs[1] = '{14'd1234,  16'h1234, 1'b0};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0};
        vecs[3] = '{14'd10000, 16'hFFFF, 1'b1};
        vecs[4] = '{14'd16383, 16'hFFFF, 1'b1};
        vecs[5] = '{14'd1,     16'h0001, 1'b0};
        vecs[6] = '{14'd5,     16'h0005, 1'b0};
        vecs[7] = '{14'd9000,  16'h9000, 1'b0};
        vecs[8] = '{14'd4095,  16'h4095, 1'b0};
        vecs[9] = '{14'd8191,  16'h8191, 1'b0};

        reset       = 1'b1;
        intf.start  = 1'b0;
        intf.number = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(intf.busy), 32'd0);
        check("rst_done", 32'(intf.done), 32'd0);
        check("rst_bcd",  32'(intf.bcd),  32'd0);
        check("rst_ovf",  32'(intf.ovf),  32'd0);

        // Start presented together with reset release: taken on the first edge.
        reset = 1'b0;
        for (int i = 0; i < 10; i++)
            run_one(vecs[i].num, -1, 14'd0, exp_t'{vecs[i].bcd, vecs[i].ovf});

        // Outputs hold between completions.
        repeat (5) @(negedge clk);
        check("hold_bcd", 32'(intf.bcd), 32'h8191);
        check("hold_ovf", 32'(intf.ovf), 32'd0);

        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(0, 16383));
            run_one(14'(n), -1, 14'd0, model(n));
        end

        // Input change during a conversion has no effect.
        run_one(14'd321, 3, 14'd999, exp_t'{16'h0321, 1'b0});

        // Start while busy ignored; start in the done cycle accepted.
        intf.number = 14'd42;
        intf.start  = 1'b1;
        sb.push_back(exp_t'{16'h0042, 1'b0});
        @(negedge clk);
        intf.start = 1'b0;
        repeat (4) @(negedge clk);
        intf.number = 14'd7;
        intf.start  = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        k = 5;
        while (intf.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ignored_start_latency", 32'(k), 32'd14);
        intf.start = 1'b1;
        sb.push_back(exp_t'{16'h0007, 1'b0});
        @(negedge clk);
        intf.start = 1'b0;
        check("done_cycle_start_busy", 32'(intf.busy), 32'd1);
        k = 0;
        while (intf.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_cycle_start_latency", 32'(k), 32'd14);
        @(negedge clk);

        // Reset in the middle of a conversion aborts it immediately.
        intf.number = 14'd5678;
        intf.start  = 1'b1;
        sb.push_back(exp_t'{16'h5678, 1'b0});
        @(negedge clk);
        intf.start = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_bcd",  32'(intf.bcd),  32'd0);
        check("abort_busy", 32'(intf.busy), 32'd0);
        check("abort_done", 32'(intf.done), 32'd0);
        check("abort_ovf",  32'(intf.ovf),  32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_one(14'd5678, -1, 14'd0, exp_t'{16'h5678, 1'b0});

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 14, binary input width.
REQ-002 SHALL have parameter DIGITS, default 4, number of BCD output digits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port number, input, WIDTH, unsigned binary value to convert.
REQ-006 SHALL have port start, input, 1, conversion request, sampled only in IDLE.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when bcd/ovf update.
REQ-009 SHALL have port bcd, output, 4*DIGITS, packed digits; digit 0 (ones) in bits [3:0].
REQ-010 SHALL have port ovf, output, 1, latched value exceeded 10^DIGITS-1.

Function
REQ-011 SHALL implement an FSM with states IDLE and SHIFT.
REQ-012 IDLE with start=1 at edge N: latch number, clear scratch BCD, load iteration counter, go to SHIFT, set busy=1.
REQ-013 SHIFT: one shift-add-3 iteration per edge; every scratch digit >=5 gets +3, then {scratch, binary} shifts left by 1.
REQ-014 SHALL perform exactly WIDTH iterations, at edges N+1..N+WIDTH.
REQ-015 At edge N+WIDTH: update bcd and ovf, set done=1, set busy=0, return to IDLE.
REQ-016 done SHALL be high for exactly one cycle, the cycle after edge N+WIDTH.
REQ-017 Latency start-sample to done SHALL be WIDTH edges; throughput one conversion per WIDTH+1 cycles.
REQ-018 start while busy=1 SHALL be ignored; no queuing.
REQ-019 start in the done cycle SHALL be accepted as a new request (state is IDLE).
REQ-020 Latched value > 10^DIGITS-1 (e.g. 10000..16383 for defaults): bcd SHALL be all nibbles 4'hF and ovf=1; otherwise ovf=0.
REQ-021 bcd and ovf SHALL hold their last values between completions.
REQ-022 Changes on number after the start sample SHALL NOT affect the conversion in progress.
REQ-023 Scratch BCD width SHALL be 4*DIGITS+4 bits so the overflow digit is never lost before the comparison.

Reset
REQ-024 reset=1 SHALL asynchronously force state IDLE, busy=0, done=0, bcd=0, ovf=0, counter and scratch to 0.
REQ-025 reset during SHIFT SHALL abort the conversion with no done pulse; outputs show reset values.
REQ-026 First start after reset release SHALL be accepted on the first rising edge with reset=0.

Structure
REQ-027 Shared package SHALL hold the WIDTH/DIGITS defaults, the BLANK nibble constant 4'hF, and the state encoding (IDLE, SHIFT).
REQ-028 SHALL instantiate one combinational sub-module, bcd_digit_adjust (4-bit in, 4-bit out: +3 if >=5), once per scratch digit.
REQ-029 Output bcd SHALL connect directly to the downstream 7-segment display stage; BLANK renders as all segments off.

Verification
REQ-030 reset, number=0, start pulse -> done after 14 edges, bcd=16'h0000, ovf=0, busy high for 14 cycles.
REQ-031 number=1234 -> bcd=16'h1234; then number=9999 -> bcd=16'h9999, ovf=0.
REQ-032 number=10000, then 16383 -> bcd=16'hFFFF, ovf=1 each time.
REQ-033 number=42 start, then start with number=7 at edge N+5 -> ignored, bcd=16'h0042; start held high in the done cycle with number=7 -> accepted, bcd=16'h0007 after 14 more edges.
REQ-034 number=5678 start, reset asserted at edge N+7 mid-cycle -> immediate bcd=0, busy=0, no done; new start with 5678 -> bcd=16'h5678.
REQ-035 number changed from 321 to 999 during SHIFT -> bcd=16'h0321.
